// File: rtl/cotm32_pipeline_pkg.sv
// Shared pipeline types for the cotm32 core.
// PC-select encoding and hazard-controller FSM states.
package cotm32_pipeline_pkg;

  typedef enum logic [1:0] {
    PC_SEL_SEQ    = 2'd0,
    PC_SEL_BRANCH = 2'd1,
    PC_SEL_TRAP   = 2'd2,
    PC_SEL_MRET   = 2'd3
  } pc_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2
  } hz_state_t;

  typedef enum logic {
    KIND_TRAP = 1'b0,
    KIND_MRET = 1'b1
  } evt_kind_t;

endpackage

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes, PC select,
// trap/MRET sequencing and a saturating stall-cycle counter.
module hazard_ctrl
  import cotm32_pipeline_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic             i_ex_valid,
  input  logic             i_ex_is_load,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_branch_taken,
  input  logic             i_ex_trap,
  input  logic             i_ex_mret,
  input  logic             i_ex_busy,
  input  logic             i_mem_busy,
  output logic             o_pc_stall,
  output logic             o_ifid_stall,
  output logic             o_ifid_flush,
  output logic             o_idex_stall,
  output logic             o_idex_flush,
  output logic             o_exmem_stall,
  output logic             o_exmem_flush,
  output logic             o_memwb_flush,
  output logic [1:0]       o_pc_sel,
  output logic             o_trap_commit,
  output logic [CNT_W-1:0] o_stall_cnt
);

  hz_state_t        state_q, state_d;
  evt_kind_t        kind_q, kind_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  pc_sel_t          pc_sel;

  logic evt;
  logic branch;
  logic load_use;

  assign evt    = i_ex_valid & (i_ex_trap | i_ex_mret);
  assign branch = i_ex_valid & i_ex_branch_taken;

  assign load_use = i_ex_valid & i_ex_is_load
                  & (i_ex_rd != 5'd0)
                  & ((i_id_use_rs1 & (i_id_rs1 == i_ex_rd))
                   | (i_id_use_rs2 & (i_id_rs2 == i_ex_rd)));

  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    pc_sel        = PC_SEL_SEQ;
    o_pc_stall    = 1'b0;
    o_ifid_stall  = 1'b0;
    o_ifid_flush  = 1'b0;
    o_idex_stall  = 1'b0;
    o_idex_flush  = 1'b0;
    o_exmem_stall = 1'b0;
    o_exmem_flush = 1'b0;
    o_memwb_flush = 1'b0;
    o_trap_commit = 1'b0;
    if (!i_rst) begin
      unique case (state_q)
        RUN: begin
          if (evt) begin
            kind_d = (i_ex_mret & ~i_ex_trap) ? KIND_MRET : KIND_TRAP;
            if (i_mem_busy) begin
              state_d       = DRAIN;
              o_pc_stall    = 1'b1;
              o_ifid_stall  = 1'b1;
              o_idex_stall  = 1'b1;
              o_exmem_stall = 1'b1;
              o_memwb_flush = 1'b1;
            end else begin
              // Trapping instruction must not reach MEM.
              state_d       = REDIRECT;
              o_pc_stall    = 1'b1;
              o_ifid_stall  = 1'b1;
              o_idex_stall  = 1'b1;
              o_exmem_flush = 1'b1;
            end
          end else if (i_mem_busy) begin
            o_pc_stall    = 1'b1;
            o_ifid_stall  = 1'b1;
            o_idex_stall  = 1'b1;
            o_exmem_stall = 1'b1;
            o_memwb_flush = 1'b1;
          end else if (i_ex_busy) begin
            o_pc_stall    = 1'b1;
            o_ifid_stall  = 1'b1;
            o_idex_stall  = 1'b1;
            o_exmem_flush = 1'b1;
          end else if (branch) begin
            pc_sel       = PC_SEL_BRANCH;
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
          end else if (load_use) begin
            o_pc_stall   = 1'b1;
            o_ifid_stall = 1'b1;
            o_idex_flush = 1'b1;
          end
        end
        DRAIN: begin
          if (i_mem_busy) begin
            o_pc_stall    = 1'b1;
            o_ifid_stall  = 1'b1;
            o_idex_stall  = 1'b1;
            o_exmem_stall = 1'b1;
            o_memwb_flush = 1'b1;
          end else begin
            state_d       = REDIRECT;
            o_pc_stall    = 1'b1;
            o_ifid_stall  = 1'b1;
            o_idex_stall  = 1'b1;
            o_exmem_flush = 1'b1;
          end
        end
        REDIRECT: begin
          state_d       = RUN;
          pc_sel        = (kind_q == KIND_MRET) ? PC_SEL_MRET
                                                : PC_SEL_TRAP;
          o_ifid_flush  = 1'b1;
          o_idex_flush  = 1'b1;
          o_exmem_flush = 1'b1;
          o_trap_commit = 1'b1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (o_pc_stall && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= RUN;
      kind_q  <= KIND_TRAP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_pc_sel    = pc_sel;
  assign o_stall_cnt = cnt_q;

endmodule
